// File: rtl/riscv_bus_pkg.sv
// Shared definitions for responders on the CPU memory bus.
// Holds the UART register offsets, STATUS bit positions, the TX/RX state
// encodings and the write_mask polarity (1 = lane NOT written).
package riscv_bus_pkg;

  // Byte offsets inside the 16-byte UART window
  localparam logic [3:0] UART_TX_DATA = 4'h0;
  localparam logic [3:0] UART_RX_DATA = 4'h4;
  localparam logic [3:0] UART_STATUS  = 4'h8;
  localparam logic [3:0] UART_DIVISOR = 4'hC;

  // STATUS register bit positions
  localparam int STAT_TX_BUSY    = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_TX_EMPTY   = 2;
  localparam int STAT_RX_VALID   = 3;
  localparam int STAT_RX_OVERRUN = 4;

  // A write_mask bit at this value means the byte lane is left untouched
  localparam logic LANE_MASKED = 1'b1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/bus_uart_responder_sync_fifo.sv
// sync_fifo: small single-clock FIFO with first-word fall-through head.
// Ports: clk, rst_n (async active-low), push/push_data, pop, head (current
// oldest entry), full, empty. A push while full is dropped; a pop while
// empty is ignored; push and pop in the same cycle are both honoured.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/bus_uart_responder.sv
// bus_uart_responder: memory-mapped UART on the CPU shared memory bus.
// Ports: clk, reset_n (async active-low); bus side address, data_in,
// write_mask (1 = lane not written), bus_enable, write_enable, data_out
// (zero when not selected); serial uart_tx (idle high), uart_rx (async);
// tx_empty_irq (high while TX FIFO empty and shifter idle).
module bus_uart_responder
  import riscv_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDRESS = 16'h8040,
  parameter int          TX_DEPTH     = 4,
  parameter logic [15:0] DIV_RESET    = 16'd104
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [31:0] data_in,
  input  logic [3:0]  write_mask,
  output logic [31:0] data_out,
  input  logic        bus_enable,
  input  logic        write_enable,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        tx_empty_irq
);

  // ---------------- bus decode ----------------
  logic        bus_en_q_reg;
  logic        sel;
  logic        commit;
  logic [3:0]  reg_off;
  logic        wr_tx, rx_read, ovr_clr;
  logic        unused_bits;

  assign sel     = bus_enable && (address[15:4] == BASE_ADDRESS[15:4]);
  // Side effects fire once, on the first cycle of a bus_enable high period
  assign commit  = sel && !bus_en_q_reg;
  assign reg_off = {address[3:2], 2'b00};
  assign wr_tx   = commit && write_enable && (reg_off == UART_TX_DATA) &&
                   (write_mask[0] != LANE_MASKED);
  assign rx_read = commit && !write_enable && (reg_off == UART_RX_DATA);
  assign ovr_clr = commit && write_enable && (reg_off == UART_STATUS) &&
                   (write_mask[0] != LANE_MASKED) && data_in[STAT_RX_OVERRUN];
  assign unused_bits = ^{address[1:0], data_in[31:16], write_mask[3:2]};

  // ---------------- divisor ----------------
  logic [15:0] div_reg, div_eff, bit_reload, half_reload;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_en_q_reg <= 1'b0;
      div_reg      <= DIV_RESET;
    end else begin
      bus_en_q_reg <= bus_enable;
      if (commit && write_enable && reg_off == UART_DIVISOR) begin
        if (write_mask[0] != LANE_MASKED) div_reg[7:0]  <= data_in[7:0];
        if (write_mask[1] != LANE_MASKED) div_reg[15:8] <= data_in[15:8];
      end
    end
  end

  // 0 and 1 both mean one clock per bit; counters reload at bit boundaries,
  // so a divisor change mid-frame applies from the next bit on.
  assign div_eff     = (div_reg < 16'd2) ? 16'd1 : div_reg;
  assign bit_reload  = div_eff - 16'd1;
  assign half_reload = ((div_eff >> 1) == 16'd0) ? 16'd0 : (div_eff >> 1) - 16'd1;

  // ---------------- TX path ----------------
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_head;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (wr_tx),
    .push_data (data_in[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  tx_state_t   tx_state_reg, tx_state_next;
  logic [15:0] tx_cnt_reg;
  logic [7:0]  tx_shift_reg;
  logic [2:0]  tx_bit_reg;
  logic        tx_tick, tx_busy, tx_empty;

  assign tx_tick = (tx_cnt_reg == 16'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_state_reg <= TX_IDLE;
    else          tx_state_reg <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      TX_IDLE:  if (!fifo_empty) tx_state_next = TX_START;
      TX_START: if (tx_tick) tx_state_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_next = TX_IDLE;
      default:  tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    uart_tx  = 1'b1;
    tx_busy  = (tx_state_reg != TX_IDLE);
    fifo_pop = (tx_state_reg == TX_IDLE) && !fifo_empty;
    case (tx_state_reg)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shift_reg[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_cnt_reg   <= '0;
      tx_shift_reg <= '0;
      tx_bit_reg   <= '0;
    end else if (tx_state_reg == TX_IDLE) begin
      if (!fifo_empty) begin
        tx_shift_reg <= fifo_head;
        tx_cnt_reg   <= bit_reload;
        tx_bit_reg   <= 3'd0;
      end
    end else if (tx_tick) begin
      tx_cnt_reg <= bit_reload;
      if (tx_state_reg == TX_DATA) begin
        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
        tx_bit_reg   <= tx_bit_reg + 3'd1;
      end
    end else begin
      tx_cnt_reg <= tx_cnt_reg - 16'd1;
    end
  end

  assign tx_empty     = fifo_empty && !tx_busy;
  assign tx_empty_irq = tx_empty;

  // ---------------- RX path ----------------
  logic [1:0]  rx_sync_reg;
  logic        rx_prev_reg, rx_s, rx_fall, rx_tick, rx_done;
  rx_state_t   rx_state_reg, rx_state_next;
  logic [15:0] rx_cnt_reg;
  logic [7:0]  rx_shift_reg, rx_byte_reg;
  logic [2:0]  rx_bit_reg;
  logic        rx_valid_reg, rx_overrun_reg;

  assign rx_s    = rx_sync_reg[1];
  assign rx_fall = rx_prev_reg && !rx_s;
  assign rx_tick = (rx_cnt_reg == 16'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_state_reg <= RX_IDLE;
    else          rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
      // Line back high at the start-bit midpoint: treat as a glitch
      RX_START: if (rx_tick) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  // A low stop sample is a framing error: the byte is simply not stored
  always_comb begin
    rx_done = (rx_state_reg == RX_STOP) && rx_tick && rx_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_reg    <= 2'b11;
      rx_prev_reg    <= 1'b1;
      rx_cnt_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_bit_reg     <= '0;
      rx_byte_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      rx_sync_reg <= {rx_sync_reg[0], uart_rx};
      rx_prev_reg <= rx_s;
      if (rx_state_reg == RX_IDLE) begin
        if (rx_fall) begin
          rx_cnt_reg <= half_reload;
          rx_bit_reg <= 3'd0;
        end
      end else if (rx_tick) begin
        rx_cnt_reg <= bit_reload;
        if (rx_state_reg == RX_DATA) begin
          rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
          rx_bit_reg   <= rx_bit_reg + 3'd1;
        end
      end else begin
        rx_cnt_reg <= rx_cnt_reg - 16'd1;
      end

      // A read coinciding with completion consumes the old byte, so the
      // new one lands as fresh data rather than as an overrun.
      if (rx_done) begin
        rx_byte_reg  <= rx_shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_read) begin
        rx_valid_reg <= 1'b0;
      end

      if (rx_done && rx_valid_reg && !rx_read) rx_overrun_reg <= 1'b1;
      else if (ovr_clr)                        rx_overrun_reg <= 1'b0;
    end
  end

  // ---------------- read mux ----------------
  logic [4:0] status;

  always_comb begin
    status                  = '0;
    status[STAT_TX_BUSY]    = tx_busy;
    status[STAT_TX_FULL]    = fifo_full;
    status[STAT_TX_EMPTY]   = tx_empty;
    status[STAT_RX_VALID]   = rx_valid_reg;
    status[STAT_RX_OVERRUN] = rx_overrun_reg;
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      case (reg_off)
        UART_RX_DATA: data_out = {23'b0, rx_valid_reg, rx_byte_reg};
        UART_STATUS:  data_out = {27'b0, status};
        UART_DIVISOR: data_out = {16'b0, div_reg};
        default:      data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart_responder.sv
// Scoreboard bench for bus_uart_responder: bus reads push their expected
// value into a queue popped by a read monitor; TX writes push expected bytes
// popped by a serial monitor that decodes uart_tx frames.
module tb_bus_uart_responder;

  localparam logic [15:0] BASE = 16'h8040;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] address;
  logic [31:0] data_in;
  logic [3:0]  write_mask;
  logic [31:0] data_out;
  logic        bus_enable;
  logic        write_enable;
  logic        uart_tx;
  logic        uart_rx;
  logic        tx_empty_irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_exp_q [$];
  string       rd_name_q [$];
  logic [7:0]  tx_exp_q [$];
  logic        rd_strobe = 1'b0;
  logic        tx_mon_en = 1'b0;
  int          tx_div = 4;

  always #5 clk = ~clk;

  bus_uart_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .data_in      (data_in),
    .write_mask   (write_mask),
    .data_out     (data_out),
    .bus_enable   (bus_enable),
    .write_enable (write_enable),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx),
    .tx_empty_irq (tx_empty_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] m);
    @(posedge clk); #1;
    address = a; data_in = d; write_mask = m; write_enable = we;
    bus_enable = 1'b1; rd_strobe = !we;
    @(posedge clk); #1;
    bus_enable = 1'b0; write_enable = 1'b0; rd_strobe = 1'b0;
  endtask

  task automatic expect_read(input string name, input logic [15:0] a, input logic [31:0] exp);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    bus_xfer(1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic tx_write(input logic [7:0] b, input logic expect_frame);
    if (expect_frame) tx_exp_q.push_back(b);
    bus_xfer(1'b1, BASE + 16'h0, {4{b}}, 4'b0000);
  endtask

  task automatic send_rx(input logic [7:0] b, input int d);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (d) @(posedge clk);
    end
  endtask

  // Read monitor: compares data_out mid-cycle during every read transaction
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (rd_strobe) begin
        if (rd_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got 0x%0h expected none", data_out);
        end else begin
          e = rd_exp_q.pop_front();
          n = rd_name_q.pop_front();
          check(n, data_out, e);
        end
      end
    end
  end

  // Serial monitor: decodes each uart_tx frame at bit midpoints
  initial begin
    logic [7:0] b;
    logic       stop_bit;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_mon_en && reset_n && uart_tx == 1'b0) begin
        repeat (tx_div + tx_div / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = uart_tx;
          if (i < 7) repeat (tx_div) @(negedge clk);
        end
        repeat (tx_div) @(negedge clk);
        stop_bit = uart_tx;
        if (tx_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected_frame: got 0x%0h expected none", b);
        end else begin
          e = tx_exp_q.pop_front();
          check("tx_frame_byte", {24'b0, b}, {24'b0, e});
        end
        check("tx_stop_bit", {31'b0, stop_bit}, 32'h1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; address = '0; data_in = '0; write_mask = '0;
    bus_enable = 1'b0; write_enable = 1'b0; uart_rx = 1'b1;
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset state
    check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("reset_irq", {31'b0, tx_empty_irq}, 32'h1);
    check("idle_data_out", data_out, 32'h0);
    expect_read("reset_divisor", BASE + 16'hC, 32'd104);
    expect_read("reset_status", BASE + 16'h8, 32'h4);
    expect_read("unselected_read", BASE + 16'h18, 32'h0);

    // Single frame 0x55 at div=4
    bus_xfer(1'b1, BASE + 16'hC, 32'd4, 4'b0000);
    tx_div = 4; tx_mon_en = 1'b1;
    tx_write(8'h55, 1'b1);
    repeat (12) @(posedge clk); #1;
    check("irq_during_frame", {31'b0, tx_empty_irq}, 32'h0);
    expect_read("status_busy", BASE + 16'h8, 32'h1);
    repeat (40) @(posedge clk); #1;
    check("irq_after_frame", {31'b0, tx_empty_irq}, 32'h1);
    expect_read("status_idle", BASE + 16'h8, 32'h4);

    // FIFO fill: five fit (one in shifter), sixth dropped
    for (int i = 1; i <= 5; i++) tx_write(i[7:0], 1'b1);
    expect_read("status_full", BASE + 16'h8, 32'h3);
    tx_write(8'h06, 1'b0);
    expect_read("status_full_after_drop", BASE + 16'h8, 32'h3);
    repeat (260) @(posedge clk); #1;
    expect_read("status_drained", BASE + 16'h8, 32'h4);
    check("tx_frames_outstanding", tx_exp_q.size(), 32'h0);

    // RX single byte 0xA3 at div=8
    bus_xfer(1'b1, BASE + 16'hC, 32'd8, 4'b0000);
    send_rx(8'hA3, 8);
    repeat (4) @(posedge clk);
    expect_read("status_rx_valid", BASE + 16'h8, 32'hC);
    expect_read("rx_data_first", BASE + 16'h4, 32'h1A3);
    expect_read("rx_data_second", BASE + 16'h4, 32'h0A3);

    // Overrun: two bytes without a read
    send_rx(8'h11, 8);
    send_rx(8'h22, 8);
    repeat (4) @(posedge clk);
    expect_read("status_overrun", BASE + 16'h8, 32'h1C);
    expect_read("rx_data_overrun", BASE + 16'h4, 32'h122);
    bus_xfer(1'b1, BASE + 16'h8, 32'h10101010, 4'b0000);
    expect_read("status_overrun_cleared", BASE + 16'h8, 32'h4);

    // Divisor lane masking
    bus_xfer(1'b1, BASE + 16'hE, 32'h00100010, 4'b0011);
    expect_read("divisor_upper_lanes", BASE + 16'hC, 32'h8);
    bus_xfer(1'b1, BASE + 16'hC, 32'h20202020, 4'b1110);
    expect_read("divisor_byte0", BASE + 16'hC, 32'h20);

    // Quarter-bit start glitch at div=32
    uart_rx = 1'b0;
    repeat (8) @(posedge clk);
    uart_rx = 1'b1;
    repeat (400) @(posedge clk);
    expect_read("status_glitch_rejected", BASE + 16'h8, 32'h4);

    // Asynchronous reset in the middle of a TX frame
    tx_mon_en = 1'b0;
    tx_write(8'h00, 1'b0);
    repeat (10) @(posedge clk); #1;
    check("tx_start_bit_low", {31'b0, uart_tx}, 32'h0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("async_reset_irq", {31'b0, tx_empty_irq}, 32'h1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    expect_read("status_after_reset", BASE + 16'h8, 32'h4);
    expect_read("divisor_after_reset", BASE + 16'hC, 32'd104);

    repeat (3) @(posedge clk);
    check("reads_outstanding", rd_exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
